// File: rtl/uart_transmitter_pkg.sv
// Constants and types shared by the UART transmitter and its baud counter.
// Holds the FSM state encodings and the frame geometry.
package uart_transmitter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = 10;

endpackage : uart_transmitter_pkg

// File: rtl/uart_transmitter_baud_counter.sv
// Bit-period timer: counts cycles while enabled and ticks on the last cycle of
// each serial bit. It restarts from zero at every bit boundary.
module uart_baud_counter #(
    parameter int unsigned SymbolEdgeTime = 10
) (
    input  logic Clock,
    input  logic Reset,
    input  logic i_enable,
    output logic o_tick
);

    localparam int unsigned CntWidth = (SymbolEdgeTime > 1) ? $clog2(SymbolEdgeTime) : 1;
    localparam logic [CntWidth-1:0] LastCount = CntWidth'(SymbolEdgeTime - 1);

    logic [CntWidth-1:0] r_count;
    logic                w_last;

    assign w_last = (r_count == LastCount);
    assign o_tick = i_enable && w_last;

    always_ff @(posedge Clock) begin
        if (Reset || !i_enable || w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule : uart_baud_counter

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: accepts one byte on a valid/ready handshake and shifts
// it out LSB first between a start bit and a stop bit on a registered TX line.
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int unsigned ClockFreq = 50_000_000,
    parameter int unsigned BaudRate  = 115_200
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] DataIn,
    input  logic       DataInValid,
    output logic       DataInReady,
    output logic       SerialOut
);

    localparam int unsigned SymbolEdgeTime = ClockFreq / BaudRate;
    localparam logic [2:0]  LastBit        = 3'(DATA_BITS - 1);

    tx_state_e              r_state;
    tx_state_e              w_next_state;
    logic [DATA_BITS-1:0]   r_shift;
    logic [2:0]             r_bit_cnt;
    logic                   r_serial;
    logic                   w_tick;
    logic                   w_busy;
    logic                   w_accept;

    uart_baud_counter #(
        .SymbolEdgeTime(SymbolEdgeTime)
    ) u_baud_counter (
        .Clock    (Clock),
        .Reset    (Reset),
        .i_enable (w_busy),
        .o_tick   (w_tick)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  if (w_accept) w_next_state = START;
            START: if (w_tick) w_next_state = DATA;
            DATA:  if (w_tick && (r_bit_cnt == LastBit)) w_next_state = STOP;
            STOP:  if (w_tick) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        DataInReady = (r_state == IDLE);
        w_busy      = (r_state != IDLE);
        w_accept    = DataInValid && (r_state == IDLE);
    end

    // The line is driven from a register, so each bit value is loaded on the
    // edge that ends the previous bit; the shift register pre-rotates to match.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_serial  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shift   <= DataIn;
                        r_bit_cnt <= '0;
                        r_serial  <= 1'b0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_serial  <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_bit_cnt == LastBit) begin
                            r_serial <= 1'b1;
                        end else begin
                            r_serial  <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                STOP: r_serial <= 1'b1;
                default: r_serial <= 1'b1;
            endcase
        end
    end

    assign SerialOut = r_serial;

endmodule : uart_transmitter

// File: tb/tb_uart_transmitter.sv
// Lock-step bench: a frame-level reference model predicts the TX line and the
// ready flag every cycle for directed scenarios followed by random traffic.
module tb_uart_transmitter;
    import uart_transmitter_pkg::*;

    localparam int unsigned ClkHz = 100;
    localparam int unsigned Baud  = 10;
    localparam int unsigned Sym   = ClkHz / Baud;
    localparam int unsigned FrameCycles = FRAME_BITS * Sym;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       vld;
    logic       rdy;
    logic       txd;

    int unsigned n_vec;
    int unsigned n_err;

    // reference model: cycles since acceptance plus the 10-bit frame image
    bit          m_busy;
    int unsigned m_t;
    logic [9:0]  m_frame;

    uart_transmitter #(
        .ClockFreq(ClkHz),
        .BaudRate (Baud)
    ) dut (
        .Clock       (clk),
        .Reset       (rst),
        .DataIn      (din),
        .DataInValid (vld),
        .DataInReady (rdy),
        .SerialOut   (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Drive inputs (caller sits on a falling edge), advance one rising edge,
    // update the model from the same inputs, then compare on the next falling edge.
    task automatic step(input logic r, input logic v, input logic [7:0] d);
        rst = r;
        vld = v;
        din = d;
        @(posedge clk);
        if (r) begin
            m_busy = 1'b0;
            m_t    = 0;
        end else if (!m_busy && v) begin
            m_busy  = 1'b1;
            m_t     = 0;
            m_frame = {1'b1, d, 1'b0};
        end else if (m_busy) begin
            m_t++;
            if (m_t == FrameCycles) m_busy = 1'b0;
        end
        @(negedge clk);
        check_eq("ready", 32'(rdy), 32'(!m_busy));
        check_eq("txd", 32'(txd), m_busy ? 32'(m_frame[m_t / Sym]) : 32'd1);
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        m_busy  = 1'b0;
        m_t     = 0;
        m_frame = '1;
        rst = 1'b1;
        vld = 1'b0;
        din = '0;

        // reset for two cycles, then idle
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00);

        // single frame 0xA5 with the literal expected bit pattern cross-checked
        begin
            logic [9:0] pat;
            pat = 10'b11_0100_1010; // stop,1,0,1,0,0,1,0,1,start read right-to-left
            step(1'b0, 1'b1, 8'hA5);
            for (int i = 0; i < int'(FrameCycles); i++) begin
                check_eq("a5_bit", 32'(txd), 32'(pat[i / int'(Sym)]));
                step(1'b0, 1'b0, 8'h00);
            end
            check_eq("a5_done_ready", 32'(rdy), 32'd1);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00);

        // back-to-back: 0x00 then 0xFF with valid held
        step(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < int'(FrameCycles); i++) step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b1, 8'hFF);
        check_eq("b2b_start", 32'(txd), 32'd0);
        for (int i = 0; i < int'(FrameCycles) + 3; i++) step(1'b0, 1'b0, 8'h00);

        // busy-time valid pulse and data change are ignored
        step(1'b0, 1'b1, 8'h3C);
        for (int i = 1; i < int'(FrameCycles) + 3; i++) begin
            if (i == 30) step(1'b0, 1'b1, 8'h81);
            else         step(1'b0, 1'b0, 8'($urandom));
        end

        // reset mid-frame at cycle 45, then a clean frame
        step(1'b0, 1'b1, 8'hF0);
        for (int i = 1; i < 45; i++) step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        check_eq("abort_txd", 32'(txd), 32'd1);
        step(1'b0, 1'b0, 8'h00);
        check_eq("abort_ready", 32'(rdy), 32'd1);
        step(1'b0, 1'b1, 8'h3C);
        for (int i = 0; i < int'(FrameCycles) + 2; i++) step(1'b0, 1'b0, 8'h00);

        // reset and valid on the same edge: no frame
        step(1'b1, 1'b1, 8'h55);
        check_eq("rst_vld_txd", 32'(txd), 32'd1);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 8'h55);

        // random traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 399) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_uart_transmitter
